// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
// One operation in flight: accept in IDLE, sample the ALU in EXEC, hold the response in RESP.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [CTRL_WIDTH-1:0] req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [CTRL_WIDTH-1:0] req1_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_z,
  input  logic                  alu_overflow,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_z,
  output logic                  rsp_overflow,
  input  logic                  rsp_ready,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [CTRL_WIDTH-1:0] r_op;
  logic                  r_id;
  logic [DATA_WIDTH-1:0] r_z;
  logic                  r_ovf;
  logic                  r_rsp_valid;
  logic [15:0]           r_op_count;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;

  // On contention the requester that was not served last wins.
  assign w_idle   = (r_state == IDLE) && !reset;
  assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

  assign req0_ready   = w_grant0;
  assign req1_ready   = w_grant1;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_ctrl     = r_op;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_id;
  assign rsp_z        = r_z;
  assign rsp_overflow = r_ovf;
  assign op_count     = r_op_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_z          <= '0;
      r_ovf        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_op_count   <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0) begin
            r_a          <= req0_a;
            r_b          <= req0_b;
            r_op         <= req0_op;
            r_id         <= 1'b0;
            r_last_grant <= 1'b0;
            r_state      <= EXEC;
          end else if (w_grant1) begin
            r_a          <= req1_a;
            r_b          <= req1_b;
            r_op         <= req1_op;
            r_id         <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_z         <= alu_z;
          r_ovf       <= alu_overflow;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          // Returning to IDLE here means the handshake cycle itself never accepts.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_z;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_z;
  logic        rsp_overflow;
  logic        rsp_ready;
  logic [15:0] op_count;

  int n_chk = 0;
  int n_err = 0;

  alu_share_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_z(alu_z), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_overflow(rsp_overflow), .rsp_ready(rsp_ready),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: 000 add, 001 sub, 010 and, 111 shift left by 17 (overflow = bit shifted out).
  always_comb begin
    alu_overflow = 1'b0;
    case (alu_ctrl)
      3'b000: alu_z = alu_a + alu_b;
      3'b001: alu_z = alu_a - alu_b;
      3'b010: alu_z = alu_a & alu_b;
      3'b111: begin
        alu_z        = alu_a << 17;
        alu_overflow = alu_a[15];
      end
      default: alu_z = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h0; req0_b = 32'h0; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 32'h0; req1_b = 32'h0; req1_op = 3'd0;
    rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Single request from req0
    req0_valid = 1'b1; req0_a = 32'h0123; req0_b = 32'h2222; req0_op = 3'b000;
    #1;
    chk("single_ready0", {31'd0, req0_ready}, 32'd1);
    chk("single_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("single_exec_ready0", {31'd0, req0_ready}, 32'd0);
    chk("single_exec_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("single_exec_alu_a", alu_a, 32'h0123);
    chk("single_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("single_rsp_z", rsp_z, 32'h00002345);
    chk("single_rsp_ovf", {31'd0, rsp_overflow}, 32'd0);
    chk("single_count_before", {16'd0, op_count}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("single_done_count", {16'd0, op_count}, 32'd1);
    chk("single_alu_hold", alu_a, 32'h0123);

    // Alternation after reset: req0 (1+2=3) then req1 (10-5=5)
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd5; req1_op = 3'b001;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt%0d_ready0", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_ready1", i), {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      @(negedge clk);
      chk($sformatf("alt%0d_exec_ready", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("alt%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("alt%0d_rsp_id", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("alt%0d_rsp_z", i), rsp_z, (i % 2 == 0) ? 32'd3 : 32'd5);
      chk($sformatf("alt%0d_resp_ready", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
    end
    chk("alt_count", {16'd0, op_count}, 32'd4);

    // Backpressure: both valid, req0 wins (last grant was req1), response stalled 5 cycles
    rsp_ready = 1'b0;
    req0_a = 32'd5; req0_b = 32'd6; req0_op = 3'b000;
    #1;
    chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_z", i), rsp_z, 32'd11);
      chk($sformatf("bp%0d_id", i), {31'd0, rsp_id}, 32'd0);
      chk($sformatf("bp%0d_readys", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      chk($sformatf("bp%0d_count", i), {16'd0, op_count}, 32'd4);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_done_count", {16'd0, op_count}, 32'd5);
    chk("bp_next_ready1", {31'd0, req1_ready}, 32'd1);
    chk("bp_next_ready0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Overflow forwarded for one response only
    req0_valid = 1'b1; req0_a = 32'h8000; req0_b = 32'd0; req0_op = 3'b111;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("ovf_exec_ctrl", {29'd0, alu_ctrl}, 32'd7);
    @(negedge clk);
    chk("ovf_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ovf_rsp_ovf", {31'd0, rsp_overflow}, 32'd1);
    chk("ovf_rsp_z", rsp_z, 32'd0);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 3'b000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("ovf_next_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ovf_next_ovf", {31'd0, rsp_overflow}, 32'd0);
    chk("ovf_next_z", rsp_z, 32'd7);
    @(negedge clk);
    chk("ovf_count", {16'd0, op_count}, 32'd7);

    // Reset during EXEC abandons the operation
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rexec_valid0", {31'd0, rsp_valid}, 32'd0);
    chk("rexec_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    chk("rexec_valid1", {31'd0, rsp_valid}, 32'd0);
    req1_valid = 1'b1; req1_a = 32'h20; req1_b = 32'h3; req1_op = 3'b001;
    #1;
    chk("rexec_ready1", {31'd0, req1_ready}, 32'd1);
    chk("rexec_ready0", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rexec_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rexec_rsp_id", {31'd0, rsp_id}, 32'd1);
    chk("rexec_rsp_z", rsp_z, 32'h1D);
    @(negedge clk);
    chk("rexec_count1", {16'd0, op_count}, 32'd1);

    // Counter wrap: preload as if 65535 operations had completed
    force dut.r_op_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_op_count;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'b000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("wrap_rsp_z", rsp_z, 32'd4);
    chk("wrap_count_before", {16'd0, op_count}, 32'h0000FFFF);
    @(negedge clk);
    chk("wrap_count", {16'd0, op_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
